// File: rtl/vitals_pkg.sv
// Shared types and limits for the vitals sample front end.
// Holds the FSM state encoding, output saturation limits and a clamp helper.
package vitals_pkg;

    typedef enum logic [1:0] {
        StWarmup,
        StRun,
        StFault
    } vitals_state_e;

    localparam int unsigned HR_MAX        = 255;
    localparam int unsigned STEP_RATE_MAX = 3;

    function automatic int unsigned saturate(input int unsigned value,
                                             input int unsigned max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/vitals_sample_frontend_if.sv
// Sensor-pulse inputs and once-per-second vitals sample outputs.
// The front end uses master; the downstream stages use slave.
interface vitals_sample_frontend_if;
    logic       beat_in;
    logic       step_in;
    logic [7:0] hr_bpm;
    logic [1:0] step_rate;
    logic       sample_valid;
    logic       sensor_fault;
    logic       warming_up;

    modport master (
        input  beat_in, step_in,
        output hr_bpm, step_rate, sample_valid, sensor_fault, warming_up
    );

    modport slave (
        output beat_in, step_in,
        input  hr_bpm, step_rate, sample_valid, sensor_fault, warming_up
    );
endinterface

// File: rtl/pulse_sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detector.
// The one-cycle pulse on rise_o appears two clocks after the input rises.
module pulse_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic pulse_i,
    output logic rise_o
);
    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= pulse_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
endmodule

// File: rtl/vitals_sample_frontend.sv
// Turns raw beat/step pulses into a sliding-window heart rate and a per-second cadence,
// strobing one sample per second and flagging loss of the beat signal.
module vitals_sample_frontend
    import vitals_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = 10,
    parameter int unsigned WIN_SEC       = 15,
    parameter int unsigned FAULT_SEC     = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    vitals_sample_frontend_if.master  bus
);
    localparam int unsigned HrMult = 60 / WIN_SEC;
    localparam int unsigned SumW   = $clog2(15 * WIN_SEC + 1);
    localparam int unsigned PtrW   = (WIN_SEC > 1) ? $clog2(WIN_SEC) : 1;
    localparam int unsigned FillW  = $clog2(WIN_SEC + 1);
    localparam int unsigned PreW   = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int unsigned SilW   = $clog2(FAULT_SEC + 1);

    logic beat_rise;
    logic step_rise;

    pulse_sync_edge u_beat_sync (
        .clk     (clk),
        .rst     (rst),
        .pulse_i (bus.beat_in),
        .rise_o  (beat_rise)
    );

    pulse_sync_edge u_step_sync (
        .clk     (clk),
        .rst     (rst),
        .pulse_i (bus.step_in),
        .rise_o  (step_rise)
    );

    logic [PreW-1:0]  presc_q;
    logic [3:0]       beat_cnt_q;
    logic [2:0]       step_cnt_q;
    logic [3:0]       win_q [WIN_SEC];
    logic [SumW-1:0]  sum_q;
    logic [PtrW-1:0]  wr_ptr_q;
    logic [FillW-1:0] fill_q;
    logic [SilW-1:0]  silent_q;
    vitals_state_e    state_q;
    logic [7:0]       hr_q;
    logic [1:0]       rate_q;
    logic             valid_q;
    logic             fault_q;
    logic             warm_q;

    logic             sec_strobe;
    logic             fault_exit;
    logic [SumW-1:0]  next_sum;
    logic [15:0]      hr_wide;
    logic [7:0]       hr_sat;
    logic [1:0]       rate_sat;
    logic [SilW-1:0]  silent_next;
    logic [FillW-1:0] fill_next;
    logic [PtrW-1:0]  wr_ptr_next;
    logic             fault_hit;

    always_comb begin
        sec_strobe  = (presc_q == PreW'(TICKS_PER_SEC - 1));
        fault_exit  = (state_q == StFault) && beat_rise;
        // The outgoing entry is always part of the sum, so this never underflows.
        next_sum    = sum_q - SumW'(win_q[wr_ptr_q]) + SumW'(beat_cnt_q);
        hr_wide     = 16'(next_sum) * 16'(HrMult);
        hr_sat      = 8'(saturate(32'(hr_wide), HR_MAX));
        rate_sat    = 2'(saturate(32'(step_cnt_q), STEP_RATE_MAX));
        fill_next   = fill_q + FillW'(1);
        wr_ptr_next = (wr_ptr_q == PtrW'(WIN_SEC - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        if (beat_cnt_q != 4'd0) begin
            silent_next = '0;
        end else if (silent_q == SilW'(FAULT_SEC)) begin
            silent_next = silent_q;
        end else begin
            silent_next = silent_q + SilW'(1);
        end
        fault_hit = (silent_next == SilW'(FAULT_SEC));
    end

    // Prescaler and per-second pulse counters; an edge on the strobe opens the new second.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            beat_cnt_q <= '0;
            step_cnt_q <= '0;
        end else begin
            presc_q <= sec_strobe ? '0 : presc_q + PreW'(1);

            if (sec_strobe || fault_exit) begin
                beat_cnt_q <= beat_rise ? 4'd1 : 4'd0;
            end else if (beat_rise && beat_cnt_q != 4'd15) begin
                beat_cnt_q <= beat_cnt_q + 4'd1;
            end

            if (sec_strobe) begin
                step_cnt_q <= step_rise ? 3'd1 : 3'd0;
            end else if (step_rise && step_cnt_q != 3'd7) begin
                step_cnt_q <= step_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIN_SEC; i++) begin
                win_q[i] <= '0;
            end
            sum_q    <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            silent_q <= '0;
            state_q  <= StWarmup;
            hr_q     <= '0;
            rate_q   <= '0;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
            warm_q   <= 1'b1;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                StFault: begin
                    if (beat_rise) begin
                        for (int i = 0; i < WIN_SEC; i++) begin
                            win_q[i] <= '0;
                        end
                        sum_q    <= '0;
                        fill_q   <= '0;
                        silent_q <= '0;
                        fault_q  <= 1'b0;
                        warm_q   <= 1'b1;
                        state_q  <= StWarmup;
                    end else if (sec_strobe) begin
                        silent_q <= silent_next;
                    end
                end
                default: begin
                    if (sec_strobe) begin
                        win_q[wr_ptr_q] <= beat_cnt_q;
                        sum_q           <= next_sum;
                        wr_ptr_q        <= wr_ptr_next;
                        silent_q        <= silent_next;
                        if (state_q == StWarmup) begin
                            fill_q <= fill_next;
                        end
                        // Losing the beat outranks completing warm-up: no sample this second.
                        if (fault_hit) begin
                            state_q <= StFault;
                            fault_q <= 1'b1;
                            warm_q  <= 1'b0;
                        end else if (state_q == StRun || fill_next == FillW'(WIN_SEC)) begin
                            state_q <= StRun;
                            warm_q  <= 1'b0;
                            valid_q <= 1'b1;
                            hr_q    <= hr_sat;
                            rate_q  <= rate_sat;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.hr_bpm       = hr_q;
    assign bus.step_rate    = rate_q;
    assign bus.sample_valid = valid_q;
    assign bus.sensor_fault = fault_q;
    assign bus.warming_up   = warm_q;
endmodule

// File: tb/tb_vitals_sample_frontend.sv
// Directed per-second vectors for the vitals front end, plus reset sequences.
// Each row gives beats/steps for one second and the outputs expected after its strobe.
module tb_vitals_sample_frontend;
    logic clk = 1'b0;
    logic rst = 1'b1;

    vitals_sample_frontend_if bus ();

    vitals_sample_frontend #(
        .TICKS_PER_SEC (10),
        .WIN_SEC       (15),
        .FAULT_SEC     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nb;     // beats this second
        int ns;     // steps this second
        bit early;  // single beat placed so its edge lands on the opening strobe
        bit valid;
        int hr;
        int rate;
        bit fault;
        bit warm;
    } row_t;

    localparam int NumRows = 67;
    row_t tab [NumRows];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulses rise at offsets 8,6,4,2,0 of the drive window; offset 0 hits the strobe edge.
    function automatic bit pulse_at(input int n, input bit early, input int m);
        if (early) return (n > 0) && (m == 0);
        for (int i = 0; i < n; i++) begin
            if (m == 8 - 2 * i) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check({tag, " valid"}, int'(bus.sample_valid), 0);
        check({tag, " hr"},    int'(bus.hr_bpm), 0);
        check({tag, " rate"},  int'(bus.step_rate), 0);
        check({tag, " fault"}, int'(bus.sensor_fault), 0);
        check({tag, " warm"},  int'(bus.warming_up), 1);
    endtask

    // Releases reset at the first negedge, then plays rows 0..last; row j is checked
    // on the negedge right after the strobe that closes second j.
    task automatic run_table(input int last);
        for (int n = 0; n <= 10 * last + 10; n++) begin
            int j;
            int m;
            @(negedge clk);
            if (n == 0) rst = 1'b0;
            j = (n + 3) / 10;
            m = (n + 3) % 10;
            if (j <= last) begin
                bus.beat_in = pulse_at(tab[j].nb, tab[j].early, m);
                bus.step_in = pulse_at(tab[j].ns, 1'b0, m);
            end else begin
                bus.beat_in = 1'b0;
                bus.step_in = 1'b0;
            end
            if (n >= 10 && n % 10 == 0) begin
                int r;
                r = (n - 10) / 10;
                check($sformatf("s%0d valid", r), int'(bus.sample_valid), int'(tab[r].valid));
                check($sformatf("s%0d hr", r),    int'(bus.hr_bpm),       tab[r].hr);
                check($sformatf("s%0d rate", r),  int'(bus.step_rate),    tab[r].rate);
                check($sformatf("s%0d fault", r), int'(bus.sensor_fault), int'(tab[r].fault));
                check($sformatf("s%0d warm", r),  int'(bus.warming_up),   int'(tab[r].warm));
            end else begin
                check($sformatf("cyc%0d valid quiet", n), int'(bus.sample_valid), 0);
            end
        end
    endtask

    initial begin
        int hr_up [15]   = '{128, 140, 152, 164, 176, 188, 200, 212, 224, 236, 248,
                             255, 255, 255, 255};
        int hr_down [15] = '{255, 255, 255, 252, 240, 228, 216, 204, 192, 180, 168,
                             156, 144, 132, 120};

        // Warm-up at 2 beats/s and 2 steps/s: first sample closes second 14.
        for (int j = 0; j < 14; j++) tab[j] = '{2, 2, 0, 0, 0, 0, 0, 1};
        tab[14] = '{2, 2, 0, 1, 120, 2, 0, 0};
        tab[15] = '{2, 5, 0, 1, 120, 3, 0, 0};
        tab[16] = '{2, 0, 0, 1, 120, 0, 0, 0};
        // Lone beat on the strobe edge belongs to second 17 (2 leaves, 1 enters).
        tab[17] = '{1, 1, 1, 1, 116, 1, 0, 0};
        for (int k = 0; k < 15; k++) tab[18 + k] = '{5, 1, 0, 1, hr_up[k], 1, 0, 0};
        for (int k = 0; k < 15; k++) tab[33 + k] = '{2, 2, 0, 1, hr_down[k], 2, 0, 0};
        // Beats stop: two more samples, then fault on the third silent strobe.
        tab[48] = '{0, 2, 0, 1, 112, 2, 0, 0};
        tab[49] = '{0, 2, 0, 1, 104, 2, 0, 0};
        tab[50] = '{0, 2, 0, 0, 104, 2, 1, 0};
        tab[51] = '{0, 2, 0, 0, 104, 2, 1, 0};
        tab[52] = '{1, 2, 0, 0, 104, 2, 0, 1};
        for (int j = 53; j < 66; j++) tab[j] = '{2, 2, 0, 0, 104, 2, 0, 1};
        tab[66] = '{2, 2, 0, 1, 116, 2, 0, 0};

        bus.beat_in = 1'b0;
        bus.step_in = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");

        run_table(NumRows - 1);

        // Reset lands mid-cycle while the last sample strobe is still high.
        #2 rst = 1'b1;
        #1 check_idle_outputs("async reset");
        repeat (2) @(negedge clk);
        check_idle_outputs("held reset");

        run_table(14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vitals_sample_frontend.md
Name: vitals_sample_frontend

Overview:
Upstream stage of the step calculator and the HR/step comparator. Converts raw sensor pulses into once-per-second vitals samples.
- Beat pulses from the PPG comparator become a sliding-window heart rate in BPM.
- Footstep pulses from the pedometer become a per-second cadence.
- One-cycle sample_valid strobe per second; outputs connect directly to hr_input, steps_per_second and valid_input of the downstream stages.
- Flags sensor loss when no beat is seen for a configurable time.

Parameters:
TICKS_PER_SEC, 10, clk cycles per one-second sample period; the default is for simulation.
WIN_SEC, 15, HR window length in seconds; must divide 60.
FAULT_SEC, 3, consecutive beat-free seconds that raise sensor_fault.

Ports:
clk  in  1  system clock (single clock domain)
rst  in  1  reset, asynchronous, active-high
beat_in  in  1  raw heartbeat pulse, asynchronous level
step_in  in  1  raw footstep pulse, asynchronous level
hr_bpm  out  8  windowed heart rate in BPM, saturated
step_rate  out  2  steps in the last second, saturated at 3
sample_valid  out  1  one-cycle strobe when new hr_bpm/step_rate is presented
sensor_fault  out  1  beat signal lost
warming_up  out  1  window not yet full; no valid samples issued

Behaviour:
- Reset is asynchronous and active-high; it clears all state immediately:
  - all outputs 0 except warming_up=1;
  - prescaler 0, window buffer and running sum 0, write pointer 0;
  - silent-second counter 0, FSM=WARMUP, fill counter 0.
- Input path: beat_in and step_in each pass through a 2-FF synchronizer, then a rising-edge detector. An edge registers in the count 3 cycles after the input rises.
- Prescaler: counts 0..TICKS_PER_SEC-1. sec_strobe is asserted in the cycle where the count equals TICKS_PER_SEC-1.
- Per-second counters:
  - beat_cnt is 4 bits and saturates at 15; step_cnt is 3 bits and saturates at 7.
  - An edge in the sec_strobe cycle belongs to the new second: the counter loads 1 instead of 0.
- Window: circular buffer of WIN_SEC 4-bit entries with a running sum of 8 bits or more. On sec_strobe:
  - next_sum = sum - buf[wr_ptr] + beat_cnt;
  - buf[wr_ptr] <= beat_cnt;
  - wr_ptr wraps from WIN_SEC-1 to 0.
- HR arithmetic: hr = next_sum * (60/WIN_SEC), computed at 10 bits or more. If the result exceeds 255 it is saturated to 255.
- Output timing (registered on the edge that ends the sec_strobe cycle, so outputs appear 1 cycle after the strobe):
  - hr_bpm and step_rate = min(step_cnt,3) update only when the FSM is RUN at the strobe, or when WARMUP completes at it;
  - sample_valid pulses high for exactly that one cycle;
  - otherwise hr_bpm and step_rate hold their values.
- FSM:
  - WARMUP: the fill counter increments on each sec_strobe. When it reaches WIN_SEC, the FSM moves to RUN and that same strobe produces the first sample_valid. warming_up=1 while in this state.
  - RUN: emits a sample every second.
  - FAULT: sensor_fault=1 and no sample_valid. On the first beat edge, it clears the buffer, sum and fill counter, drops sensor_fault, and moves to WARMUP.
- Fault detection:
  - The silent-second counter increments on each strobe whose closing beat_cnt is 0, and clears on any nonzero count.
  - When it reaches FAULT_SEC, the FSM moves from WARMUP or RUN to FAULT. sensor_fault rises 1 cycle after that strobe, and that strobe emits no sample.
- Simultaneous beat edge and FAULT-exit: exit takes priority, and the edge counts as 1 in the new beat_cnt.
- Reset mid-operation: there are no partial-sample outputs. sample_valid deasserts asynchronously.

Decomposition:
- Shared package vitals_pkg holds:
  - FSM state enum (WARMUP, RUN, FAULT);
  - HR_MAX=255 and STEP_RATE_MAX=3;
  - a saturate function.
- One natural sub-module: pulse_sync_edge (2-FF synchronizer plus rising-edge detect). It is instantiated twice, for beat and step.

Test Plan (defaults: 10 cycles/s, 15 s window, 3 s fault):
- 2 beats/s and 2 steps/s from reset → no sample_valid for the first 14 s. At the end of second 15: sample_valid=1 for 1 cycle, hr_bpm=120, step_rate=2, warming_up=0.
- Steady state, then 5 steps/s → step_rate=3 (saturated). Then 0 steps in one second → step_rate=0 on the next sample.
- 5 beats/s for 15 s → next_sum=75, 75*4=300 → hr_bpm=255.
- Beats stop in RUN → samples continue for 2 s, with hr dropping by 8 per silent second once 2/s entries leave. At the 3rd silent strobe: sensor_fault=1 and no valid. A beat resumes → sensor_fault=0, warming_up=1, next valid 15 s later.
- Beat edge placed exactly in the sec_strobe cycle → counted in the following second's entry, verified through the hr change after the window rolls.
- rst asserted mid-cycle while sample_valid=1 → all outputs clear asynchronously before the next clk edge. After release, the warm-up restarts for a full 15 s.
